// File: rtl/s32_minmax_tracker_pkg.sv
// Shared types and defaults for the signed min/max frame tracker.
package s32_minmax_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 16;

  // Saturation value of the beat counter at the default index width.
  localparam logic [DEF_CNT_W-1:0] CNT_MAX = {DEF_CNT_W{1'b1}};

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/s32_minmax_tracker_if.sv
// Stream-in / result-out bundle for the min/max tracker.
interface s32_minmax_tracker_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_data;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_min;
  logic signed [WIDTH-1:0] out_max;
  logic        [CNT_W-1:0] out_min_idx;
  logic        [CNT_W-1:0] out_max_idx;
  logic        [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_min, out_max, out_min_idx, out_max_idx, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_min, out_max, out_min_idx, out_max_idx, out_count
  );
endinterface

// File: rtl/s32_minmax_tracker_lteq.sv
// Combinational signed a <= b comparator.
module s32_lteq #(
  parameter int WIDTH = 32
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic                    le
);
  assign le = (a <= b);
endmodule

// File: rtl/s32_minmax_tracker.sv
// Per-frame signed min/max tracker with first-occurrence indices and saturating beat count.
module s32_minmax_tracker
  import s32_minmax_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  s32_minmax_tracker_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_SAT) ? c : c + 1'b1;
  endfunction

  state_e                  state_q, state_d;
  logic signed [WIDTH-1:0] min_q, min_d;
  logic signed [WIDTH-1:0] max_q, max_d;
  logic        [CNT_W-1:0] min_idx_q, min_idx_d;
  logic        [CNT_W-1:0] max_idx_q, max_idx_d;
  logic        [CNT_W-1:0] cnt_q, cnt_d;
  logic                    lo_le, hi_le;
  logic                    accept;

  s32_lteq #(.WIDTH(WIDTH)) u_lo (.a(min_q),       .b(bus.in_data), .le(lo_le));
  s32_lteq #(.WIDTH(WIDTH)) u_hi (.a(bus.in_data), .b(max_q),       .le(hi_le));

  // Ready is a function of state only; reset holds it low.
  assign bus.in_ready = ~rst & (state_q != HOLD);
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    state_d   = state_q;
    min_d     = min_q;
    max_d     = max_q;
    min_idx_d = min_idx_q;
    max_idx_d = max_idx_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          min_d     = bus.in_data;
          max_d     = bus.in_data;
          min_idx_d = '0;
          max_idx_d = '0;
          cnt_d     = {{(CNT_W-1){1'b0}}, 1'b1};
          state_d   = bus.in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          // Strict comparisons only: ties keep the first occurrence.
          if (!lo_le) begin
            min_d     = bus.in_data;
            min_idx_d = cnt_q;
          end
          if (!hi_le) begin
            max_d     = bus.in_data;
            max_idx_d = cnt_q;
          end
          cnt_d = cnt_sat_inc(cnt_q);
          if (bus.in_last) state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EMPTY;
      min_q     <= '0;
      max_q     <= '0;
      min_idx_q <= '0;
      max_idx_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      max_q     <= max_d;
      min_idx_q <= min_idx_d;
      max_idx_q <= max_idx_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.out_valid   = (state_q == HOLD);
  assign bus.out_min     = min_q;
  assign bus.out_max     = max_q;
  assign bus.out_min_idx = min_idx_q;
  assign bus.out_max_idx = max_idx_q;
  assign bus.out_count   = cnt_q;

endmodule
